ip_spi_command: RTL
===================

IP_SPI_COMMAND -- requirements
Module: ip_spi_command

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the SDRAM write byte-FIFO depth (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port n_reset, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port spi_cs_n, input, 1 bit: frame select, already synchronised to clk; 1 means no frame.
REQ-005 SHALL have port rx_valid, input, 1 bit: one-cycle pulse marking a received byte.
REQ-006 SHALL have port rx_data, input, 8 bits: the received byte, valid when rx_valid=1.
REQ-007 SHALL have port tx_data, output, 8 bits: the reply byte the SPI shifter transmits for the next byte.
REQ-008 SHALL have ports key_we (output, 1 bit), key_y (output, 4 bits) and key_x (output, 8 bits): key-matrix row write strobe, row and data.
REQ-009 SHALL have ports sdram_req (output, 1 bit), sdram_ack (input, 1 bit), sdram_address (output, 23 bits) and sdram_wdata (output, 8 bits): the byte-write handshake.
REQ-010 SHALL have port sdram_busy, input, 1 bit: 1 while SDRAM initialisation is not complete.
REQ-011 SHALL have ports cpu_reset (output, 1 bit) and cpu_enable (output, 1 bit): CPU reset pulse and CPU run enable.

Function
REQ-012 SHALL use the FSM states ST_IDLE, ST_ARG1, ST_ARG2, ST_DATA and ST_IGNORE.
REQ-013 SHALL return to ST_IDLE within 1 cycle, from any state, on spi_cs_n=1, and clear the data offset.
REQ-014 SHALL, in ST_IDLE with a byte received, decode the command: 00h->ST_IGNORE; 02h sets cpu_enable=1 then ST_IGNORE; 03h->ST_ARG1; 04h->ST_ARG1; 05h->ST_ARG1; 06h pulses cpu_reset high for 1 cycle then ST_IGNORE; 07h->ST_ARG1; any other value->ST_IGNORE.
REQ-015 SHALL, for command 03h, latch Y[3:0] in ST_ARG1 and X in ST_ARG2, then pulse key_we for 1 cycle, 1 cycle after X is received.
REQ-016 SHALL, for command 07h, set bank[8] to arg[0] and then go to ST_IGNORE.
REQ-017 SHALL, for command 04h, set bank[7:0] to arg and offset to 0 and then go to ST_DATA; each data byte is pushed to the FIFO with address {bank[8:0],offset[13:0]} and the offset then increments.
REQ-018 SHALL wrap the offset from 3FFFh to 0000h, with the bank unchanged.
REQ-019 SHALL hold tx_data=A5h as its default reply; after the 05h command byte it loads {6'b0,overflow,sdram_busy} for the next byte and then returns to A5h.
REQ-020 SHALL drive sdram_req high while the FIFO is non-empty, with address and wdata taken from the FIFO head; a pop occurs on a cycle with sdram_req=1 and sdram_ack=1, and req may stay high back-to-back.
REQ-021 SHALL, when the FIFO is full and a data byte arrives, drop the byte, set a sticky overflow flag and still increment the offset.
REQ-022 SHALL clear the overflow flag only on reset or on a 04h command byte.
REQ-023 SHALL perform a push and a pop in the same cycle at full or empty without loss and without a change of count.
REQ-024 SHALL keep frame termination from flushing the FIFO; queued writes complete.

Reset
REQ-025 SHALL, while n_reset=0 at a clk edge, reset: state=ST_IDLE, bank=000h, offset=0, FIFO empty, overflow=0, tx_data=A5h, key_we=0, key_y=0, key_x=FFh, sdram_req=0, sdram_address=0, sdram_wdata=0, cpu_reset=0, cpu_enable=0.
REQ-026 SHALL, on reset mid-frame or mid-burst, discard all pending FIFO entries.

Configuration
REQ-027 SHALL compile the key-matrix command 03h in when the macro IP_SPI_COMMAND_KEYMAP_EN is defined.
REQ-028 SHALL, without IP_SPI_COMMAND_KEYMAP_EN, decode 03h as an unknown command (ST_IGNORE), tie key_we=0, key_y=0 and key_x=FFh, and not create key registers.

Structure
REQ-029 SHALL place command codes (CMD_*), the state enum, the A5h reply constant and the address widths (bank 9, offset 14) in package ip_spi_command_pkg.
REQ-030 SHALL implement the FIFO as the sub-module ip_spi_command_fifo (parameter FIFO_DEPTH, 31-bit entries {address,data}).

Verification
REQ-031 SHALL verify: frame {00h} -> reply A5h; cpu, key and sdram outputs unchanged.
REQ-032 SHALL verify: frame {03h,05h,7Eh} -> key_we is a single 1-cycle pulse with key_y=5 and key_x=7Eh (macro defined); with the macro undefined, no pulse occurs.
REQ-033 SHALL verify: sdram_busy=1, frame {05h,00h} -> the second reply is 01h; with sdram_busy=0 it is 00h.
REQ-034 SHALL verify: frames {07h,01h} then {04h,02h,AAh,BBh} with sdram_ack always 1 -> writes 408000h=AAh, then 408001h=BBh, in order.
REQ-035 SHALL verify: sdram_ack=0, FIFO_DEPTH=4, frame {04h,00h} + 5 data bytes -> 4 entries queued, the 5th dropped and the status bit1 reads 1; after sdram_ack=1 exactly 4 writes occur at addresses 0..3.
REQ-036 SHALL verify: n_reset asserted after 2 queued bytes -> sdram_req=0 on the next cycle, tx_data=A5h and the state is idle; no further writes occur.

Source files
------------

// File: rtl/ip_spi_command_pkg.sv
// Shared definitions for the SPI command decoder: command codes, FSM states,
// the idle reply byte and the SDRAM address field widths.
package ip_spi_command_pkg;

  // Command bytes recognised in the first byte of a frame
  localparam logic [7:0] CMD_NOP       = 8'h00;
  localparam logic [7:0] CMD_CPU_RUN   = 8'h02;
  localparam logic [7:0] CMD_KEY       = 8'h03;
  localparam logic [7:0] CMD_BANK_LO   = 8'h04;
  localparam logic [7:0] CMD_STATUS    = 8'h05;
  localparam logic [7:0] CMD_CPU_RESET = 8'h06;
  localparam logic [7:0] CMD_BANK_HI   = 8'h07;

  // Reply byte shifted out whenever no status is pending
  localparam logic [7:0] REPLY_IDLE = 8'hA5;

  // SDRAM address = {bank, offset}; a FIFO entry is {address, data}
  localparam int BANK_W   = 9;
  localparam int OFFSET_W = 14;
  localparam int ADDR_W   = BANK_W + OFFSET_W;
  localparam int FIFO_W   = ADDR_W + 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARG1   = 3'd1,
    ST_ARG2   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

endpackage

// File: rtl/ip_spi_command_fifo.sv
// Byte-write FIFO between the SPI data phase and the SDRAM write port.
// Show-ahead: the head entry is visible while the FIFO is non-empty; the head
// reads as zero when empty so the SDRAM bus is quiet after reset.
// A push is accepted when not full, or when full but popping in the same cycle.
module ip_spi_command_fifo
  import ip_spi_command_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              push,
  input  logic [FIFO_W-1:0] push_data,
  input  logic              pop,
  output logic [FIFO_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [FIFO_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              pop_ok;
  logic              push_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  // Storage write; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards every pending entry
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ip_spi_command.sv
// SPI command decoder: parses framed command bytes, drives CPU control,
// the optional key-matrix row writer, a status reply and a buffered SDRAM
// byte-write stream addressed by {bank, offset}.
// Optional feature: define IP_SPI_COMMAND_KEYMAP_EN to build command 03h
// (key-matrix row write); otherwise 03h is ignored and key outputs are tied.
module ip_spi_command
  import ip_spi_command_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              spi_cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              key_we,
  output logic [3:0]        key_y,
  output logic [7:0]        key_x,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [7:0]        sdram_wdata,
  input  logic              sdram_busy,
  output logic              cpu_reset,
  output logic              cpu_enable
);

  state_t              state_reg;
  logic [7:0]          cmd_reg;
  logic [BANK_W-1:0]   bank_reg;
  logic [OFFSET_W-1:0] offset_reg;
  logic                overflow_reg;
  logic [7:0]          tx_data_reg;
  logic                cpu_reset_reg;
  logic                cpu_enable_reg;

  logic                byte_in;
  logic                data_byte;
  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_pop;
  logic                fifo_drop;
  logic [FIFO_W-1:0]   fifo_head;

  // A byte only counts while the frame is selected
  assign byte_in   = rx_valid && !spi_cs_n;
  assign data_byte = byte_in && (state_reg == ST_DATA);
  assign fifo_pop  = sdram_req && sdram_ack;
  assign fifo_drop = data_byte && fifo_full && !fifo_pop;

  assign sdram_req                    = !fifo_empty;
  assign {sdram_address, sdram_wdata} = fifo_head;
  assign tx_data                      = tx_data_reg;
  assign cpu_reset                    = cpu_reset_reg;
  assign cpu_enable                   = cpu_enable_reg;

  ip_spi_command_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (data_byte),
    .push_data ({bank_reg, offset_reg, rx_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Frame parser: command decode, arguments, bank/offset, status reply, CPU control
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg      <= ST_IDLE;
      cmd_reg        <= 8'h00;
      bank_reg       <= '0;
      offset_reg     <= '0;
      overflow_reg   <= 1'b0;
      tx_data_reg    <= REPLY_IDLE;
      cpu_reset_reg  <= 1'b0;
      cpu_enable_reg <= 1'b0;
    end else begin
      cpu_reset_reg <= 1'b0;
      if (spi_cs_n) begin
        // End of frame: queued writes keep draining, only the parser restarts
        state_reg   <= ST_IDLE;
        offset_reg  <= '0;
        tx_data_reg <= REPLY_IDLE;
      end else if (rx_valid) begin
        case (state_reg)
          ST_IDLE: begin
            cmd_reg <= rx_data;
            case (rx_data)
              CMD_NOP: state_reg <= ST_IGNORE;
              CMD_CPU_RUN: begin
                cpu_enable_reg <= 1'b1;
                state_reg      <= ST_IGNORE;
              end
`ifdef IP_SPI_COMMAND_KEYMAP_EN
              CMD_KEY: state_reg <= ST_ARG1;
`else
              CMD_KEY: state_reg <= ST_IGNORE;
`endif
              CMD_BANK_LO: begin
                overflow_reg <= 1'b0;
                state_reg    <= ST_ARG1;
              end
              CMD_STATUS: begin
                tx_data_reg <= {6'b0, overflow_reg, sdram_busy};
                state_reg   <= ST_ARG1;
              end
              CMD_CPU_RESET: begin
                cpu_reset_reg <= 1'b1;
                state_reg     <= ST_IGNORE;
              end
              CMD_BANK_HI: state_reg <= ST_ARG1;
              default:     state_reg <= ST_IGNORE;
            endcase
          end
          ST_ARG1: begin
            case (cmd_reg)
              CMD_BANK_LO: begin
                bank_reg[7:0] <= rx_data;
                offset_reg    <= '0;
                state_reg     <= ST_DATA;
              end
              CMD_BANK_HI: begin
                bank_reg[8] <= rx_data[0];
                state_reg   <= ST_IGNORE;
              end
              CMD_STATUS: begin
                // Status has been shifted out with this byte
                tx_data_reg <= REPLY_IDLE;
                state_reg   <= ST_IGNORE;
              end
`ifdef IP_SPI_COMMAND_KEYMAP_EN
              CMD_KEY: state_reg <= ST_ARG2;
`endif
              default: state_reg <= ST_IGNORE;
            endcase
          end
          ST_ARG2: state_reg <= ST_IGNORE;
          ST_DATA: begin
            // Offset advances even for a dropped byte so later bytes keep their address
            offset_reg <= offset_reg + OFFSET_W'(1);
            if (fifo_drop) begin
              overflow_reg <= 1'b1;
            end
          end
          default: state_reg <= ST_IGNORE;
        endcase
      end
    end
  end

`ifdef IP_SPI_COMMAND_KEYMAP_EN
  logic       key_we_reg;
  logic [3:0] key_y_reg;
  logic [7:0] key_x_reg;

  assign key_we = key_we_reg;
  assign key_y  = key_y_reg;
  assign key_x  = key_x_reg;

  // Key-matrix row capture: Y from the first argument, X plus a write strobe from the second
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      key_we_reg <= 1'b0;
      key_y_reg  <= 4'h0;
      key_x_reg  <= 8'hFF;
    end else begin
      key_we_reg <= 1'b0;
      if (byte_in && (cmd_reg == CMD_KEY)) begin
        if (state_reg == ST_ARG1) begin
          key_y_reg <= rx_data[3:0];
        end else if (state_reg == ST_ARG2) begin
          key_x_reg  <= rx_data;
          key_we_reg <= 1'b1;
        end
      end
    end
  end
`else
  assign key_we = 1'b0;
  assign key_y  = 4'h0;
  assign key_x  = 8'hFF;
`endif

endmodule
